control_pipeline: RTL and testbench

//  Second-generation RV32I control path: decodes the ID-stage opcode and carries the control bundle through
//  the ID/EX, EX/MEM, (optional extra MEM) and MEM/WB pipeline registers.

---
 rtl/ctrl_pkg.sv | 103 ++++++++++
 rtl/ctrl_stage_reg.sv | 23 ++
 rtl/control_pipeline.sv | 121 ++++++++++++
 tb/tb_control_pipeline.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Control-path types for the RV32I pipeline: opcode constants, select enums,
// the per-stage control bundle and the ID-stage decode table.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic       {B_RS2, B_IMM} b_sel_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_RFUNCT, ALU_IFUNCT, ALU_BRCMP} alu_op_e;
    typedef enum logic [1:0] {NPC_PC4, NPC_BRANCH, NPC_JALR, NPC_JAL} npc_sel_e;

    // valid must stay the first member: stage registers test the MSB as valid
    typedef struct packed {
        logic     valid;
        logic     write;
        logic     load;
        logic     store;
        logic     branch;
        a_sel_e   a_sel;
        b_sel_e   b_sel;
        alu_op_e  alu_op;
        npc_sel_e npc_sel;
    } ctrl_bundle_t;

    localparam int CTRL_W  = $bits(ctrl_bundle_t);
    localparam int VLD_BIT = CTRL_W - 1;

    typedef struct packed {
        ctrl_bundle_t ctl;
        imm_sel_e     imm_sel;
        logic         legal;
    } decode_t;

    function automatic decode_t decode(input logic [6:0] opcode);
        decode_t d;
        d           = '0;
        d.legal     = 1'b1;
        d.ctl.valid = 1'b1;
        case (opcode)
            OP_R: begin
                d.ctl.write  = 1'b1;
                d.ctl.alu_op = ALU_RFUNCT;
            end
            OP_I: begin
                d.ctl.write  = 1'b1;
                d.ctl.b_sel  = B_IMM;
                d.ctl.alu_op = ALU_IFUNCT;
            end
            OP_LOAD: begin
                d.ctl.write = 1'b1;
                d.ctl.load  = 1'b1;
                d.ctl.b_sel = B_IMM;
            end
            OP_STORE: begin
                d.ctl.store = 1'b1;
                d.ctl.b_sel = B_IMM;
                d.imm_sel   = IMM_S;
            end
            OP_BRANCH: begin
                d.ctl.branch  = 1'b1;
                d.ctl.alu_op  = ALU_BRCMP;
                d.ctl.npc_sel = NPC_BRANCH;
                d.imm_sel     = IMM_B;
            end
            OP_JALR: begin
                d.ctl.write   = 1'b1;
                d.ctl.b_sel   = B_IMM;
                d.ctl.npc_sel = NPC_JALR;
            end
            OP_AUIPC: begin
                d.ctl.write = 1'b1;
                d.ctl.a_sel = A_PC;
                d.ctl.b_sel = B_IMM;
                d.imm_sel   = IMM_U;
            end
            OP_LUI: begin
                d.ctl.write = 1'b1;
                d.ctl.a_sel = A_ZERO;
                d.ctl.b_sel = B_IMM;
                d.imm_sel   = IMM_U;
            end
            OP_JAL: begin
                d.ctl.write   = 1'b1;
                d.ctl.a_sel   = A_PC;
                d.ctl.b_sel   = B_IMM;
                d.ctl.npc_sel = NPC_JAL;
                d.imm_sel     = IMM_J;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register for the control bundle. An invalid or bubbled input
// is stored as all-zero so every stage presents zero controls when not valid.
module ctrl_stage_reg
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic [CTRL_W-1:0] d,
    output logic [CTRL_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (bubble || !d[VLD_BIT]) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// RV32I control path: decodes the ID opcode and carries the control bundle through EX, MEM(+extra) and WB.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 7,
    parameter int EXTRA_MEM_STG = 0,
    parameter int CNT_W         = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode_id,
    input  logic                valid_id,
    input  logic                stall,
    input  logic                flush,
    output logic [2:0]          imm_sel_id,
    output logic                illegal_id,
    output logic                ex_valid,
    output logic [1:0]          ex_alu_a_sel,
    output logic                ex_alu_b_sel,
    output logic [2:0]          ex_alu_op,
    output logic                ex_branch,
    output logic [1:0]          ex_next_pc_sel,
    output logic                mem_valid,
    output logic                mem_load,
    output logic                mem_store,
    output logic                wb_valid,
    output logic                wb_write,
    output logic [CNT_W-1:0]    perf_retired,
    output logic [CNT_W-1:0]    perf_bubbles,
    output logic [CNT_W-1:0]    perf_illegal
);

    // Stage index: 0 = EX, 1..N_MEM = MEM stages, N_MEM+1 = WB
    localparam int N_MEM   = 1 + EXTRA_MEM_STG;
    localparam int N_STG   = N_MEM + 2;
    localparam int MEM_IDX = N_MEM;
    localparam int WB_IDX  = N_STG - 1;

    decode_t           dec;
    logic              bubble_id;
    logic [CTRL_W-1:0] ctl_p [N_STG];
    ctrl_bundle_t      ex_c;
    ctrl_bundle_t      mem_c;
    ctrl_bundle_t      wb_c;
    logic              unused_ok;

    assign dec        = decode(opcode_id[6:0]);
    assign imm_sel_id = dec.imm_sel;
    assign illegal_id = valid_id & ~dec.legal;
    // stall and flush both squash the instruction entering EX; flush taking priority is therefore moot
    assign bubble_id  = ~valid_id | illegal_id | stall | flush;

    for (genvar i = 0; i < N_STG; i++) begin : g_stage
        logic [CTRL_W-1:0] d_in;
        logic              bub;
        if (i == 0) begin : g_ex
            assign d_in = dec.ctl;
            assign bub  = bubble_id;
        end else begin : g_down
            assign d_in = ctl_p[i-1];
            assign bub  = 1'b0;
        end
        ctrl_stage_reg u_reg (
            .clk    (clk),
            .rst    (rst),
            .bubble (bub),
            .d      (d_in),
            .q      (ctl_p[i])
        );
    end

    assign ex_c  = ctrl_bundle_t'(ctl_p[0]);
    assign mem_c = ctrl_bundle_t'(ctl_p[MEM_IDX]);
    assign wb_c  = ctrl_bundle_t'(ctl_p[WB_IDX]);
    assign unused_ok = ^{ex_c, mem_c, wb_c};

    assign ex_valid       = ex_c.valid;
    assign ex_alu_a_sel   = ex_c.a_sel;
    assign ex_alu_b_sel   = ex_c.b_sel;
    assign ex_alu_op      = ex_c.alu_op;
    assign ex_branch      = ex_c.branch;
    assign ex_next_pc_sel = ex_c.npc_sel;
    assign mem_valid      = mem_c.valid;
    assign mem_load       = mem_c.load;
    assign mem_store      = mem_c.store;
    assign wb_valid       = wb_c.valid;
    assign wb_write       = wb_c.write;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] bubbles_q;
    logic [CNT_W-1:0] illegal_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + {{(CNT_W-1){1'b0}}, 1'b1} : c;
    endfunction

    // retired counts on the edge an instruction enters WB
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            bubbles_q <= '0;
            illegal_q <= '0;
        end else begin
            retired_q <= sat_inc(retired_q, ctl_p[WB_IDX-1][VLD_BIT]);
            bubbles_q <= sat_inc(bubbles_q, valid_id & (stall | flush | illegal_id));
            illegal_q <= sat_inc(illegal_q, illegal_id);
        end
    end

    assign perf_retired = retired_q;
    assign perf_bubbles = bubbles_q;
    assign perf_illegal = illegal_q;
`else
    assign perf_retired = '0;
    assign perf_bubbles = '0;
    assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: two instances (EXTRA_MEM_STG=0 and 2) share stimulus;
// a history queue of expected bundles supplies the EX/MEM/WB expectations for each.
module tb_control_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode_id;
    logic       valid_id, stall, flush;

    logic [2:0]  imm_sel   [2];
    logic        illegal   [2];
    logic        ex_valid  [2];
    logic [1:0]  ex_a      [2];
    logic        ex_b      [2];
    logic [2:0]  ex_op     [2];
    logic        ex_br     [2];
    logic [1:0]  ex_npc    [2];
    logic        mem_valid [2];
    logic        mem_load  [2];
    logic        mem_store [2];
    logic        wb_valid  [2];
    logic        wb_write  [2];
    logic [31:0] p_ret     [2];
    logic [31:0] p_bub     [2];
    logic [31:0] p_ill     [2];

    always #5 clk = ~clk;

    control_pipeline #(.OPCODE_W(7), .EXTRA_MEM_STG(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .opcode_id(opcode_id), .valid_id(valid_id),
        .stall(stall), .flush(flush), .imm_sel_id(imm_sel[0]), .illegal_id(illegal[0]),
        .ex_valid(ex_valid[0]), .ex_alu_a_sel(ex_a[0]), .ex_alu_b_sel(ex_b[0]),
        .ex_alu_op(ex_op[0]), .ex_branch(ex_br[0]), .ex_next_pc_sel(ex_npc[0]),
        .mem_valid(mem_valid[0]), .mem_load(mem_load[0]), .mem_store(mem_store[0]),
        .wb_valid(wb_valid[0]), .wb_write(wb_write[0]),
        .perf_retired(p_ret[0]), .perf_bubbles(p_bub[0]), .perf_illegal(p_ill[0])
    );

    control_pipeline #(.OPCODE_W(7), .EXTRA_MEM_STG(2), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .opcode_id(opcode_id), .valid_id(valid_id),
        .stall(stall), .flush(flush), .imm_sel_id(imm_sel[1]), .illegal_id(illegal[1]),
        .ex_valid(ex_valid[1]), .ex_alu_a_sel(ex_a[1]), .ex_alu_b_sel(ex_b[1]),
        .ex_alu_op(ex_op[1]), .ex_branch(ex_br[1]), .ex_next_pc_sel(ex_npc[1]),
        .mem_valid(mem_valid[1]), .mem_load(mem_load[1]), .mem_store(mem_store[1]),
        .wb_valid(wb_valid[1]), .wb_write(wb_write[1]),
        .perf_retired(p_ret[1]), .perf_bubbles(p_bub[1]), .perf_illegal(p_ill[1])
    );

    // Expected bundle layout: {valid, write, load, store, branch, a[1:0], b, op[2:0], npc[1:0]}
    typedef struct {
        logic [6:0]  op;
        logic        v;
        logic        st;
        logic        fl;
        logic [2:0]  imm;
        logic        ill;
        logic [12:0] ctl;
    } vec_t;

    localparam int NV = 20;
    vec_t        vt [NV];
    logic [12:0] hist [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_ret [2];
    int          exp_bub;
    int          exp_ill;

    logic [12:0] C_R, C_I, C_LD, C_ST, C_BR, C_JALR, C_AUIPC, C_LUI, C_JAL;

    function automatic logic [12:0] mk(input logic w, l, s, br, input logic [1:0] a,
                                       input logic b, input logic [2:0] op, input logic [1:0] npc);
        return {1'b1, w, l, s, br, a, b, op, npc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        hist = {};
        repeat (6) hist.push_front(13'd0);
        exp_ret[0] = 0;
        exp_ret[1] = 0;
        exp_bub    = 0;
        exp_ill    = 0;
    endtask

    task automatic check_stages();
        for (int d = 0; d < 2; d++) begin
            logic [12:0] e, m, w;
            int mi, wi;
            mi = (d == 0) ? 1 : 3;
            wi = mi + 1;
            e = hist[0];
            m = hist[mi];
            w = hist[wi];
            chk($sformatf("ex%0d", d),
                {22'd0, ex_valid[d], ex_a[d], ex_b[d], ex_op[d], ex_br[d], ex_npc[d]},
                {22'd0, e[12], e[7:6], e[5], e[4:2], e[8], e[1:0]});
            chk($sformatf("mem%0d", d), {29'd0, mem_valid[d], mem_load[d], mem_store[d]},
                {29'd0, m[12], m[10], m[9]});
            chk($sformatf("wb%0d", d), {30'd0, wb_valid[d], wb_write[d]}, {30'd0, w[12], w[11]});
            if (w[12]) exp_ret[d]++;
`ifdef CTRL_PERF_CNT_EN
            chk($sformatf("perf_retired%0d", d), p_ret[d], exp_ret[d]);
            chk($sformatf("perf_bubbles%0d", d), p_bub[d], exp_bub);
            chk($sformatf("perf_illegal%0d", d), p_ill[d], exp_ill);
`else
            chk($sformatf("perf_retired%0d", d), p_ret[d], 32'd0);
            chk($sformatf("perf_bubbles%0d", d), p_bub[d], 32'd0);
            chk($sformatf("perf_illegal%0d", d), p_ill[d], 32'd0);
`endif
        end
    endtask

    task automatic step(input logic [6:0] op, input logic v, st, fl,
                        input logic [2:0] ximm, input logic xill, input logic [12:0] xctl);
        opcode_id = op;
        valid_id  = v;
        stall     = st;
        flush     = fl;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("imm_sel%0d op=%0h", d, op), {29'd0, imm_sel[d]}, {29'd0, ximm});
            chk($sformatf("illegal%0d op=%0h", d, op), {31'd0, illegal[d]}, {31'd0, xill});
        end
        hist.push_front(xctl);
        if (hist.size() > 6) void'(hist.pop_back());
        if (v && (st || fl || xill)) exp_bub++;
        if (xill) exp_ill++;
        @(posedge clk);
        #1;
        check_stages();
    endtask

    task automatic rst_cycle(input logic [6:0] op, input logic v, st, fl);
        rst       = 1'b1;
        opcode_id = op;
        valid_id  = v;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #1;
        reset_model();
        check_stages();
        rst = 1'b0;
    endtask

    initial begin
        C_R     = mk(1, 0, 0, 0, 2'd0, 0, 3'd1, 2'd0);
        C_I     = mk(1, 0, 0, 0, 2'd0, 1, 3'd2, 2'd0);
        C_LD    = mk(1, 1, 0, 0, 2'd0, 1, 3'd0, 2'd0);
        C_ST    = mk(0, 0, 1, 0, 2'd0, 1, 3'd0, 2'd0);
        C_BR    = mk(0, 0, 0, 1, 2'd0, 0, 3'd3, 2'd1);
        C_JALR  = mk(1, 0, 0, 0, 2'd0, 1, 3'd0, 2'd2);
        C_AUIPC = mk(1, 0, 0, 0, 2'd1, 1, 3'd0, 2'd0);
        C_LUI   = mk(1, 0, 0, 0, 2'd2, 1, 3'd0, 2'd0);
        C_JAL   = mk(1, 0, 0, 0, 2'd1, 1, 3'd0, 2'd3);

        vt[0]  = '{7'h33, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_R};
        vt[1]  = '{7'h03, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_LD};
        vt[2]  = '{7'h23, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, C_ST};
        vt[3]  = '{7'h33, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_R};
        vt[4]  = '{7'h03, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_LD};
        vt[5]  = '{7'h33, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 13'd0};
        vt[6]  = '{7'h33, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_R};
        vt[7]  = '{7'h6F, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 13'd0};
        vt[8]  = '{7'h13, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 13'd0};
        vt[9]  = '{7'h13, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_I};
        vt[10] = '{7'h7F, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 13'd0};
        vt[11] = '{7'h63, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, C_BR};
        vt[12] = '{7'h67, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_JALR};
        vt[13] = '{7'h17, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, C_AUIPC};
        vt[14] = '{7'h37, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, C_LUI};
        vt[15] = '{7'h6F, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, C_JAL};
        vt[16] = '{7'h7F, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 13'd0};
        vt[17] = '{7'h23, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 13'd0};
        vt[18] = '{7'h63, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 13'd0};
        vt[19] = '{7'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 13'd0};

        rst = 1'b1;
        opcode_id = 7'h33;
        valid_id = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        reset_model();

        // two reset cycles with a valid R-type presented
        rst_cycle(7'h33, 1'b1, 1'b0, 1'b0);
        rst_cycle(7'h33, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++)
            step(vt[i].op, vt[i].v, vt[i].st, vt[i].fl, vt[i].imm, vt[i].ill, vt[i].ctl);

        repeat (5) step(7'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 13'd0);

        // reset arriving with loads/stores in flight and stall/flush asserted
        step(7'h03, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_LD);
        step(7'h23, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, C_ST);
        step(7'h33, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_R);
        rst_cycle(7'h03, 1'b1, 1'b1, 1'b1);
        step(7'h03, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, C_LD);
        repeat (5) step(7'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 13'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
